// File: rtl/byte_word_packer.sv
`timescale 1ns/1ps
// Streaming byte-to-word packer: gathers 8-bit bytes into 32-bit words with a lane keep mask.
// A byte flagged last closes a partial word; lane order is chosen by BIG_ENDIAN.
module byte_word_packer #(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        clk,
  input  logic        areset_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic [3:0]  out_keep,
  output logic        out_last
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [3:0]  kacc_q, kacc_d;
  logic [31:0] out_data_q, out_data_d;
  logic [3:0]  out_keep_q, out_keep_d;
  logic        out_last_q, out_last_d;
  logic        out_valid_q, out_valid_d;

  logic        in_ready_s;
  logic        in_fire_s;
  logic        out_fire_s;
  logic        complete_s;
  logic [1:0]  lane_s;
  logic [31:0] byte_word_s;
  logic [3:0]  byte_keep_s;

  // Physical lane for the k-th byte of a word.
  function automatic logic [1:0] lane_of(input logic [1:0] idx);
    if (BIG_ENDIAN) begin
      lane_of = 2'd3 - idx;
    end else begin
      lane_of = idx;
    end
  endfunction

  function automatic logic [31:0] place_byte(input logic [7:0] b, input logic [1:0] lane);
    logic [31:0] w;
    w = 32'd0;
    case (lane)
      2'd0:    w[7:0]   = b;
      2'd1:    w[15:8]  = b;
      2'd2:    w[23:16] = b;
      2'd3:    w[31:24] = b;
      default: w        = 32'd0;
    endcase
    return w;
  endfunction

  function automatic logic [3:0] lane_bit(input logic [1:0] lane);
    logic [3:0] k;
    case (lane)
      2'd0:    k = 4'b0001;
      2'd1:    k = 4'b0010;
      2'd2:    k = 4'b0100;
      2'd3:    k = 4'b1000;
      default: k = 4'b0000;
    endcase
    return k;
  endfunction

  // Handshake decode and next-state computation for accumulator and output register.
  always_comb begin
    in_ready_s  = !out_valid_q || out_ready;
    in_fire_s   = in_valid && in_ready_s;
    out_fire_s  = out_valid_q && out_ready;
    complete_s  = (cnt_q == 2'd3) || in_last;
    lane_s      = lane_of(cnt_q);
    byte_word_s = place_byte(in_data, lane_s);
    byte_keep_s = lane_bit(lane_s);

    cnt_d       = cnt_q;
    acc_d       = acc_q;
    kacc_d      = kacc_q;
    out_data_d  = out_data_q;
    out_keep_d  = out_keep_q;
    out_last_d  = out_last_q;
    out_valid_d = out_valid_q && !out_fire_s;

    if (in_fire_s && complete_s) begin
      // acc only ever holds filled lanes, so unused lanes are already zero.
      out_data_d  = acc_q | byte_word_s;
      out_keep_d  = kacc_q | byte_keep_s;
      out_last_d  = in_last;
      out_valid_d = 1'b1;
      acc_d       = 32'd0;
      kacc_d      = 4'd0;
      cnt_d       = 2'd0;
    end else if (in_fire_s) begin
      acc_d  = acc_q | byte_word_s;
      kacc_d = kacc_q | byte_keep_s;
      cnt_d  = cnt_q + 2'd1;
    end else begin
      cnt_d  = cnt_q;
      acc_d  = acc_q;
      kacc_d = kacc_q;
    end
  end

  // State and output registers.
  always_ff @(posedge clk or negedge areset_n) begin
    if (!areset_n) begin
      cnt_q       <= 2'd0;
      acc_q       <= 32'd0;
      kacc_q      <= 4'd0;
      out_data_q  <= 32'd0;
      out_keep_q  <= 4'd0;
      out_last_q  <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      kacc_q      <= kacc_d;
      out_data_q  <= out_data_d;
      out_keep_q  <= out_keep_d;
      out_last_q  <= out_last_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_s;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_keep  = out_keep_q;
  assign out_last  = out_last_q;

endmodule

// File: tb/tb_byte_word_packer.sv
`timescale 1ns/1ps
// Directed bench for byte_word_packer: a big-endian and a little-endian instance share stimulus
// and are checked against hand-computed words from a vector table plus streaming/reset sequences.
module tb_byte_word_packer;

  logic        clk;
  logic        areset_n;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_ready;

  logic        in_ready_be, out_valid_be, out_last_be;
  logic [31:0] out_data_be;
  logic [3:0]  out_keep_be;
  logic        in_ready_le, out_valid_le, out_last_le;
  logic [31:0] out_data_le;
  logic [3:0]  out_keep_le;

  int n_vec;
  int n_miss;

  typedef struct {
    logic        iv;
    logic [7:0]  id;
    logic        il;
    logic        ordy;
    logic        rdy;
    logic        ov;
    logic        chk;
    logic [31:0] dbe;
    logic [3:0]  kbe;
    logic [31:0] dle;
    logic [3:0]  kle;
    logic        lst;
    string       name;
  } vec_t;

  vec_t vecs[$];

  byte_word_packer #(.BIG_ENDIAN(1'b1)) u_be (
    .clk(clk), .areset_n(areset_n),
    .in_valid(in_valid), .in_ready(in_ready_be), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_be), .out_ready(out_ready), .out_data(out_data_be),
    .out_keep(out_keep_be), .out_last(out_last_be)
  );

  byte_word_packer #(.BIG_ENDIAN(1'b0)) u_le (
    .clk(clk), .areset_n(areset_n),
    .in_valid(in_valid), .in_ready(in_ready_le), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid_le), .out_ready(out_ready), .out_data(out_data_le),
    .out_keep(out_keep_le), .out_last(out_last_le)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic il,
                              input logic ordy, input logic rdy, input logic ov,
                              input logic chk_out, input logic [31:0] dbe, input logic [3:0] kbe,
                              input logic [31:0] dle, input logic [3:0] kle, input logic lst,
                              input string name);
    vec_t v;
    v.iv = iv; v.id = id; v.il = il; v.ordy = ordy; v.rdy = rdy; v.ov = ov;
    v.chk = chk_out; v.dbe = dbe; v.kbe = kbe; v.dle = dle; v.kle = kle; v.lst = lst;
    v.name = name;
    return v;
  endfunction

  task automatic apply_row(input vec_t v);
    @(posedge clk);
    #1;
    in_valid  = v.iv;
    in_data   = v.id;
    in_last   = v.il;
    out_ready = v.ordy;
    @(negedge clk);
    chk({v.name, " rdy_be"}, {31'd0, in_ready_be}, {31'd0, v.rdy});
    chk({v.name, " rdy_le"}, {31'd0, in_ready_le}, {31'd0, v.rdy});
    chk({v.name, " ov_be"}, {31'd0, out_valid_be}, {31'd0, v.ov});
    chk({v.name, " ov_le"}, {31'd0, out_valid_le}, {31'd0, v.ov});
    if (v.chk) begin
      chk({v.name, " data_be"}, out_data_be, v.dbe);
      chk({v.name, " keep_be"}, {28'd0, out_keep_be}, {28'd0, v.kbe});
      chk({v.name, " data_le"}, out_data_le, v.dle);
      chk({v.name, " keep_le"}, {28'd0, out_keep_le}, {28'd0, v.kle});
      chk({v.name, " last_be"}, {31'd0, out_last_be}, {31'd0, v.lst});
      chk({v.name, " last_le"}, {31'd0, out_last_le}, {31'd0, v.lst});
    end
  endtask

  task automatic chk_reset_outputs(input string name);
    chk({name, " ov"}, {30'd0, out_valid_be, out_valid_le}, 32'd0);
    chk({name, " data_be"}, out_data_be, 32'd0);
    chk({name, " data_le"}, out_data_le, 32'd0);
    chk({name, " keep"}, {24'd0, out_keep_be, out_keep_le}, 32'd0);
    chk({name, " last"}, {30'd0, out_last_be, out_last_le}, 32'd0);
    chk({name, " rdy"}, {30'd0, in_ready_be, in_ready_le}, 32'd3);
  endtask

  // Simple byte row (no output data check) and word-visible row helpers.
  function automatic vec_t by(input logic [7:0] d, input logic l, input logic ordy,
                              input logic rdy, input logic ov, input string name);
    return mk(1'b1, d, l, ordy, rdy, ov, 1'b0, 32'd0, 4'd0, 32'd0, 4'd0, 1'b0, name);
  endfunction

  function automatic vec_t idle0(input string name);
    return mk(1'b0, 8'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 4'd0, 32'd0, 4'd0, 1'b0, name);
  endfunction

  initial begin
    vec_t v;
    logic [31:0] exp_w;
    n_vec     = 0;
    n_miss    = 0;
    areset_n  = 1'b0;
    in_valid  = 1'b0;
    in_data   = 8'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Basic 4-byte word, 6-byte packet with last, backpressure, back-to-back short packets.
    vecs.push_back(idle0("idle"));
    vecs.push_back(by(8'h11, 1'b0, 1'b1, 1'b1, 1'b0, "b11"));
    vecs.push_back(by(8'h22, 1'b0, 1'b1, 1'b1, 1'b0, "b22"));
    vecs.push_back(by(8'h33, 1'b0, 1'b1, 1'b1, 1'b0, "b33"));
    vecs.push_back(by(8'h44, 1'b0, 1'b1, 1'b1, 1'b0, "b44"));
    vecs.push_back(mk(1'b1, 8'hAA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                      32'h11223344, 4'hF, 32'h44332211, 4'hF, 1'b0, "w11223344"));
    vecs.push_back(by(8'hBB, 1'b0, 1'b1, 1'b1, 1'b0, "bBB"));
    vecs.push_back(by(8'hCC, 1'b0, 1'b1, 1'b1, 1'b0, "bCC"));
    vecs.push_back(by(8'hDD, 1'b0, 1'b1, 1'b1, 1'b0, "bDD"));
    vecs.push_back(mk(1'b1, 8'hEE, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                      32'hAABBCCDD, 4'hF, 32'hDDCCBBAA, 4'hF, 1'b0, "wAABBCCDD"));
    vecs.push_back(by(8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, "bFF_last"));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                      32'hEEFF0000, 4'b1100, 32'h0000FFEE, 4'b0011, 1'b1, "wEEFF_part"));
    vecs.push_back(idle0("drain1"));
    vecs.push_back(by(8'h01, 1'b0, 1'b1, 1'b1, 1'b0, "bp01"));
    vecs.push_back(by(8'h02, 1'b0, 1'b1, 1'b1, 1'b0, "bp02"));
    vecs.push_back(by(8'h03, 1'b0, 1'b1, 1'b1, 1'b0, "bp03"));
    vecs.push_back(by(8'h04, 1'b0, 1'b1, 1'b1, 1'b0, "bp04"));
    for (int i = 0; i < 5; i++) begin
      vecs.push_back(mk(1'b1, 8'h05, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1,
                        32'h01020304, 4'hF, 32'h04030201, 4'hF, 1'b0, "stall"));
    end
    vecs.push_back(mk(1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                      32'h01020304, 4'hF, 32'h04030201, 4'hF, 1'b0, "unstall"));
    vecs.push_back(by(8'h06, 1'b0, 1'b1, 1'b1, 1'b0, "bp06"));
    vecs.push_back(by(8'h07, 1'b0, 1'b1, 1'b1, 1'b0, "bp07"));
    vecs.push_back(by(8'h08, 1'b0, 1'b1, 1'b1, 1'b0, "bp08"));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                      32'h05060708, 4'hF, 32'h08070605, 4'hF, 1'b0, "w05060708"));
    vecs.push_back(idle0("drain2"));
    vecs.push_back(by(8'h09, 1'b1, 1'b1, 1'b1, 1'b0, "b09_last"));
    vecs.push_back(mk(1'b1, 8'h0A, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1,
                      32'h09000000, 4'b1000, 32'h00000009, 4'b0001, 1'b1, "w09_single"));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                      32'h0A000000, 4'b1000, 32'h0000000A, 4'b0001, 1'b1, "w0A_nobubble"));
    vecs.push_back(idle0("drain3"));
    vecs.push_back(by(8'hB1, 1'b0, 1'b1, 1'b1, 1'b0, "bB1"));
    vecs.push_back(by(8'hB2, 1'b0, 1'b1, 1'b1, 1'b0, "bB2"));
    vecs.push_back(by(8'hB3, 1'b0, 1'b1, 1'b1, 1'b0, "bB3"));
    vecs.push_back(by(8'hB4, 1'b1, 1'b1, 1'b1, 1'b0, "bB4_last"));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                      32'hB1B2B3B4, 4'hF, 32'hB4B3B2B1, 4'hF, 1'b1, "wB1_fulllast"));
    vecs.push_back(by(8'hC1, 1'b0, 1'b1, 1'b1, 1'b0, "bC1"));
    vecs.push_back(by(8'hC2, 1'b0, 1'b1, 1'b1, 1'b0, "bC2"));
    vecs.push_back(by(8'hC3, 1'b1, 1'b1, 1'b1, 1'b0, "bC3_last"));
    vecs.push_back(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                      32'hC1C2C300, 4'b1110, 32'h00C3C2C1, 4'b0111, 1'b1, "wC1_three"));
    vecs.push_back(idle0("drain4"));

    #3;
    chk_reset_outputs("reset");
    #9;
    areset_n = 1'b1;

    foreach (vecs[i]) begin
      apply_row(vecs[i]);
    end

    // Streaming 00..0F back-to-back: one word every fourth cycle, in_ready never drops.
    for (int k = 0; k <= 16; k++) begin
      if (k < 16) begin
        v = by(k[7:0], 1'b0, 1'b1, 1'b1, 1'b0, "stream");
      end else begin
        v = idle0("stream");
      end
      if (k >= 4 && (k % 4) == 0) begin
        exp_w = {8'(k - 4), 8'(k - 3), 8'(k - 2), 8'(k - 1)};
        v.ov  = 1'b1;
        v.chk = 1'b1;
        v.dbe = exp_w;
        v.kbe = 4'hF;
        v.dle = {exp_w[7:0], exp_w[15:8], exp_w[23:16], exp_w[31:24]};
        v.kle = 4'hF;
        v.lst = 1'b0;
      end
      apply_row(v);
    end
    apply_row(idle0("stream_end"));

    // Reset after two bytes of a word: no stale lanes afterwards.
    apply_row(by(8'hAA, 1'b0, 1'b1, 1'b1, 1'b0, "rst_pre1"));
    apply_row(by(8'hBB, 1'b0, 1'b1, 1'b1, 1'b0, "rst_pre2"));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    areset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    @(negedge clk);
    areset_n = 1'b1;
    apply_row(by(8'h01, 1'b0, 1'b1, 1'b1, 1'b0, "post01"));
    apply_row(by(8'h02, 1'b0, 1'b1, 1'b1, 1'b0, "post02"));
    apply_row(by(8'h03, 1'b0, 1'b1, 1'b1, 1'b0, "post03"));
    apply_row(by(8'h04, 1'b0, 1'b1, 1'b1, 1'b0, "post04"));
    apply_row(mk(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1,
                 32'h01020304, 4'hF, 32'h04030201, 4'hF, 1'b0, "post_word"));
    apply_row(idle0("post_single"));
    apply_row(idle0("post_quiet"));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
